// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: tracks destinations of in-flight long-latency
// instructions and raises the ID-stage stall for RAW, WAW and capacity hazards.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module rf_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      idValid,
  input  logic [`RF_ADDR_WIDTH-1:0] idRs1,
  input  logic [`RF_ADDR_WIDTH-1:0] idRs2,
  input  logic                      idUsesRs1,
  input  logic                      idUsesRs2,
  input  logic [`RF_ADDR_WIDTH-1:0] idRd,
  input  logic                      idLong,
  input  logic                      flush,
  input  logic                      wbValid,
  input  logic [`RF_ADDR_WIDTH-1:0] wbRd,
  output logic                      stall,
  output logic [31:0]               pendingMask,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      full,
  output logic                      err
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      r_pending;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  logic        w_wb_live;
  logic        w_wb_hit;
  logic        w_wb_bad;
  logic        w_clr_rs1;
  logic        w_clr_rs2;
  logic        w_clr_rd;
  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_cap;
  logic        w_full;
  logic        w_stall;
  logic        w_issue;
  logic        w_set;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_pending_nxt;
  logic [CNT_W-1:0] w_outstanding_nxt;

  // A writeback in the current cycle counts as already clear (write-first RF).
  assign w_wb_live = wbValid && (wbRd != '0);
  assign w_wb_hit  = w_wb_live && r_pending[wbRd];
  assign w_wb_bad  = w_wb_live && !r_pending[wbRd];

  assign w_clr_rs1 = w_wb_live && (wbRd == idRs1);
  assign w_clr_rs2 = w_wb_live && (wbRd == idRs2);
  assign w_clr_rd  = w_wb_live && (wbRd == idRd);

  assign w_raw1 = idUsesRs1 && (idRs1 != '0) && r_pending[idRs1] && !w_clr_rs1;
  assign w_raw2 = idUsesRs2 && (idRs2 != '0) && r_pending[idRs2] && !w_clr_rs2;
  assign w_waw  = (idRd != '0) && r_pending[idRd] && !w_clr_rd;

  assign w_full = (r_outstanding == LP_MAX);
  assign w_cap  = idLong && (idRd != '0) && w_full && !w_wb_live;

  assign w_stall = idValid && !flush && (w_raw1 || w_raw2 || w_waw || w_cap);
  assign w_issue = idValid && !flush && !w_stall;
  assign w_set   = w_issue && idLong && (idRd != '0);

  // Set is applied after clear so a same-register set/clear leaves the bit at 1.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set)     w_set_mask = 32'd1 << idRd;
    if (w_wb_live) w_clr_mask = 32'd1 << wbRd;
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_set && !w_wb_hit && (r_outstanding != LP_MAX))
      w_outstanding_nxt = r_outstanding + CNT_W'(1);
    else if (w_wb_hit && !w_set && (r_outstanding != '0))
      w_outstanding_nxt = r_outstanding - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pending     <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_wb_bad) r_err <= 1'b1;
    end
  end

  assign stall       = w_stall;
  assign pendingMask = r_pending;
  assign outstanding = r_outstanding;
  assign full        = w_full;
  assign err         = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard with hand-computed expectations.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module tb_rf_scoreboard;

  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic                      clk;
  logic                      rstn;
  logic                      idValid;
  logic [`RF_ADDR_WIDTH-1:0] idRs1;
  logic [`RF_ADDR_WIDTH-1:0] idRs2;
  logic                      idUsesRs1;
  logic                      idUsesRs2;
  logic [`RF_ADDR_WIDTH-1:0] idRd;
  logic                      idLong;
  logic                      flush;
  logic                      wbValid;
  logic [`RF_ADDR_WIDTH-1:0] wbRd;
  logic                      stall;
  logic [31:0]               pendingMask;
  logic [CW-1:0]             outstanding;
  logic                      full;
  logic                      err;

  int n_cmp = 0;
  int n_bad = 0;

  rf_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .idRd(idRd), .idLong(idLong),
    .flush(flush), .wbValid(wbValid), .wbRd(wbRd), .stall(stall),
    .pendingMask(pendingMask), .outstanding(outstanding), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idValid = 0; idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    idRd = 0; idLong = 0; flush = 0; wbValid = 0; wbRd = 0;
  endtask

  task automatic drv_id(input logic lng, input logic [4:0] rd,
                        input logic u1, input logic [4:0] rs1,
                        input logic u2, input logic [4:0] rs2);
    idValid = 1; idLong = lng; idRd = rd;
    idUsesRs1 = u1; idRs1 = rs1; idUsesRs2 = u2; idRs2 = rs2;
  endtask

  task automatic drv_wb(input logic [4:0] rd);
    wbValid = 1; wbRd = rd;
  endtask

  task automatic test_reset();
    idle(); rstn = 0;
    step(); step();
    rstn = 1; #1;
    n_cmp++; if (pendingMask !== 32'h0) begin n_bad++; $display("FAIL reset_mask got=%h exp=%h", pendingMask, 32'h0); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_raw();
    drv_id(1, 5, 0, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_load_issue stall got=%b exp=0", stall); end
    step();
    // rs1 matches but is not read: no hazard
    drv_id(0, 8, 0, 5, 0, 0); #1;
    n_cmp++; if (pendingMask !== 32'h20) begin n_bad++; $display("FAIL raw_mask got=%h exp=%h", pendingMask, 32'h20); end
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL raw_outstanding got=%0d exp=1", outstanding); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_unused_rs1 stall got=%b exp=0", stall); end
    drv_id(0, 8, 0, 0, 1, 5); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_rs2 stall got=%b exp=1", stall); end
    drv_id(0, 8, 1, 5, 0, 0); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_rs1 cyc=%0d stall got=%b exp=1", i, stall); end
      step();
    end
    drv_wb(5); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_release stall got=%b exp=0", stall); end
    n_cmp++; if (pendingMask !== 32'h20) begin n_bad++; $display("FAIL raw_mask_before_wb_edge got=%h exp=%h", pendingMask, 32'h20); end
    step(); idle(); #1;
    n_cmp++; if (pendingMask !== 32'h0) begin n_bad++; $display("FAIL raw_mask_after_wb got=%h exp=0", pendingMask); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL raw_outstanding_after got=%0d exp=0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL raw_err got=%b exp=0", err); end
  endtask

  task automatic test_x0();
    drv_id(1, 0, 0, 0, 0, 0); step();
    drv_id(0, 3, 1, 0, 1, 0); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_read stall got=%b exp=0", stall); end
    drv_wb(0); step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL x0_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL x0_err got=%b exp=0", err); end
    n_cmp++; if (pendingMask !== 32'h0) begin n_bad++; $display("FAIL x0_mask got=%h exp=0", pendingMask); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      drv_id(1, 5'(r), 0, 0, 0, 0); #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL cap_fill r=%0d stall got=%b exp=0", r, stall); end
      step();
    end
    idle(); #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL cap_outstanding got=%0d exp=4", outstanding); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL cap_full got=%b exp=1", full); end
    n_cmp++; if (pendingMask !== 32'h1E) begin n_bad++; $display("FAIL cap_mask got=%h exp=%h", pendingMask, 32'h1E); end
    drv_id(1, 6, 0, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL cap_stall got=%b exp=1", stall); end
    drv_wb(0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL cap_wb_x0 stall got=%b exp=1", stall); end
    step();
    drv_wb(1); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL cap_room stall got=%b exp=0", stall); end
    step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL cap_swap_outstanding got=%0d exp=4", outstanding); end
    n_cmp++; if (pendingMask !== 32'h5C) begin n_bad++; $display("FAIL cap_swap_mask got=%h exp=%h", pendingMask, 32'h5C); end
    drv_wb(2); step(); drv_wb(3); step(); drv_wb(4); step(); drv_wb(6); step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL cap_drain got=%0d exp=0", outstanding); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL cap_drain_full got=%b exp=0", full); end
  endtask

  task automatic test_waw();
    drv_id(1, 7, 0, 0, 0, 0); step();
    drv_id(0, 7, 0, 0, 0, 0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall got=%b exp=1", stall); end
    step(); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall_hold got=%b exp=1", stall); end
    drv_id(1, 7, 0, 0, 0, 0); drv_wb(7); #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_release got=%b exp=0", stall); end
    step(); idle(); #1;
    n_cmp++; if (pendingMask !== 32'h80) begin n_bad++; $display("FAIL waw_setclr_mask got=%h exp=%h", pendingMask, 32'h80); end
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL waw_setclr_outstanding got=%0d exp=1", outstanding); end
    drv_wb(7); step(); idle(); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL waw_drain got=%0d exp=0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL waw_err got=%b exp=0", err); end
  endtask

  task automatic test_flush();
    drv_id(1, 10, 0, 0, 0, 0); step();
    drv_id(1, 11, 1, 10, 0, 0); flush = 1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    step(); flush = 0; #1;
    n_cmp++; if (pendingMask !== 32'h400) begin n_bad++; $display("FAIL flush_mask got=%h exp=%h", pendingMask, 32'h400); end
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL flush_outstanding got=%0d exp=1", outstanding); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_off_stall got=%b exp=1", stall); end
    idle(); drv_wb(10); step(); idle(); #1;
    n_cmp++; if (pendingMask !== 32'h0) begin n_bad++; $display("FAIL flush_drain got=%h exp=0", pendingMask); end
  endtask

  task automatic test_err_and_reset();
    drv_wb(9); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_early got=%b exp=0", err); end
    step(); idle(); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", err); end
    step(); step(); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    drv_id(1, 3, 0, 0, 0, 0); step(); idle(); #1;
    n_cmp++; if (pendingMask !== 32'h8) begin n_bad++; $display("FAIL rst_pre_mask got=%h exp=%h", pendingMask, 32'h8); end
    rstn = 0; step(); rstn = 1; #1;
    n_cmp++; if (pendingMask !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mask got=%h exp=0", pendingMask); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_mid_outstanding got=%0d exp=0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err got=%b exp=0", err); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_mid_full got=%b exp=0", full); end
    drv_wb(3); step(); idle(); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rst_late_wb_err got=%b exp=1", err); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_late_wb_outstanding got=%0d exp=0", outstanding); end
  endtask

  initial begin
    idle(); rstn = 0;
    test_reset();
    test_raw();
    test_x0();
    test_capacity();
    test_waw();
    test_flush();
    test_err_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
